// File: rtl/acl_master_txsched_if.sv
// Slot-timing strobes and TX grant bus between the master ACL scheduler and
// the slot timer / packet encoder side.
interface acl_master_txsched_if;
    logic       ms_tslot_p;
    logic       ms_TXslot_endp;
    logic       ms_RXslot_endp;
    logic       esco_slot;
    logic [2:0] txpk_lt_addr;
    logic [3:0] txpktype;
    logic       sched_txcmd_p;
    logic       sched_busy;
    logic       sched_err_p;

    modport master (
        input  ms_tslot_p, ms_TXslot_endp, ms_RXslot_endp, esco_slot,
        output txpk_lt_addr, txpktype, sched_txcmd_p, sched_busy, sched_err_p
    );

    modport slave (
        output ms_tslot_p, ms_TXslot_endp, ms_RXslot_endp, esco_slot,
        input  txpk_lt_addr, txpktype, sched_txcmd_p, sched_busy, sched_err_p
    );
endinterface

// File: rtl/acl_master_txsched.sv
// Master-side ACL TX slot scheduler: picks LT_ADDR and packet type for each
// master TX slot using poll-interval, data/flow and pending-ACK priority classes.
module acl_master_txsched #(
    parameter int         NLINK     = 8,
    parameter int         PCNT_W    = 8,
    parameter logic [3:0] POLL_TYPE = 4'h1,
    parameter logic [3:0] NULL_TYPE = 4'h0
) (
    input  logic                  clk_6M,
    input  logic                  rstz,
    input  logic                  sched_en,
    input  logic [NLINK-1:0]      regi_link_active,
    input  logic [NLINK-1:0]      regi_txdatready,
    input  logic [3:0]            regi_packet_type,
    input  logic [PCNT_W-1:0]     regi_tpoll,
    input  logic [NLINK-1:0]      dec_flow,
    input  logic [NLINK-1:0]      txARQN,
    acl_master_txsched_if.master  slot_if
);

    localparam int AW = $clog2(NLINK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECIDE,
        S_TX,
        S_WAITRX
    } state_t;

    state_t            state;
    logic [AW-1:0]     rr_ptr;
    logic [PCNT_W-1:0] pcnt [1:NLINK-1];

    logic [2:0]        lt_addr_q;
    logic [3:0]        pktype_q;
    logic              txcmd_q;
    logic              busy_q;
    logic              err_q;

    logic [NLINK-1:0]  p1, p2, p3, cls;
    logic              found;
    logic [AW-1:0]     win_idx;
    logic [AW-1:0]     rr_next;
    logic [3:0]        win_type;

    // Class masks and round-robin winner search starting at rr_ptr, wrapping past index 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        p1      = '0;
        p2      = '0;
        p3      = '0;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 1; i < NLINK; i++) begin
            if (regi_link_active[i]) begin
                p1[i] = (regi_tpoll != '0) && (pcnt[i] >= regi_tpoll);
                p2[i] = regi_txdatready[i] & dec_flow[i];
                p3[i] = txARQN[i];
            end
        end
        cls = (p1 != '0) ? p1 : ((p2 != '0) ? p2 : p3);
        for (int k = 0; k < NLINK - 1; k++) begin
            int c;
            c = int'(rr_ptr) + k;
            if (c > NLINK - 1) c = c - (NLINK - 1);
            if (!found && cls[c]) begin
                found   = 1'b1;
                win_idx = AW'(c);
            end
        end
        rr_next = (win_idx == AW'(NLINK - 1)) ? AW'(1) : win_idx + 1'b1;
        if (p2[win_idx])      win_type = regi_packet_type;
        else if (p1[win_idx]) win_type = POLL_TYPE;
        else                  win_type = NULL_TYPE;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state     <= S_IDLE;
            rr_ptr    <= AW'(1);
            lt_addr_q <= '0;
            pktype_q  <= '0;
            txcmd_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            // NOTE: the poll-counter array is small and must start from zero, so it is reset explicitly.
            for (int i = 1; i < NLINK; i++) pcnt[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout; a later assignment to the same counter overrides the increment.
            txcmd_q <= 1'b0;
            err_q   <= 1'b0;

            if (slot_if.ms_tslot_p) begin
                for (int i = 1; i < NLINK; i++) begin
                    if (!regi_link_active[i])  pcnt[i] <= '0;
                    else if (pcnt[i] != '1)    pcnt[i] <= pcnt[i] + 1'b1;
                end
            end

            if (!sched_en) begin
                state     <= S_IDLE;
                busy_q    <= 1'b0;
                lt_addr_q <= '0;
                pktype_q  <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (slot_if.ms_tslot_p && !slot_if.esco_slot) state <= S_DECIDE;
                    end
                    S_DECIDE: begin
                        if (slot_if.ms_tslot_p) err_q <= 1'b1;
                        if (found) begin
                            lt_addr_q     <= 3'(win_idx);
                            pktype_q      <= win_type;
                            txcmd_q       <= 1'b1;
                            busy_q        <= 1'b1;
                            rr_ptr        <= rr_next;
                            pcnt[win_idx] <= '0;
                            state         <= S_TX;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_TX: begin
                        if (slot_if.ms_tslot_p)     err_q <= 1'b1;
                        if (slot_if.ms_TXslot_endp) state <= S_WAITRX;
                    end
                    S_WAITRX: begin
                        if (slot_if.ms_tslot_p) err_q <= 1'b1;
                        if (slot_if.ms_RXslot_endp) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign slot_if.txpk_lt_addr  = lt_addr_q;
    assign slot_if.txpktype      = pktype_q;
    assign slot_if.sched_txcmd_p = txcmd_q;
    assign slot_if.sched_busy    = busy_q;
    assign slot_if.sched_err_p   = err_q;

endmodule

// File: tb/tb_acl_master_txsched.sv
// Directed bench for the master ACL TX slot scheduler: round robin, polling,
// class priority, eSCO blocking, overrun, enable drop and async reset.
module tb_acl_master_txsched;

    localparam int NLINK  = 8;
    localparam int PCNT_W = 8;

    logic              clk_6M = 1'b0;
    logic              rstz   = 1'b0;
    logic              sched_en = 1'b0;
    logic [NLINK-1:0]  regi_link_active = '0;
    logic [NLINK-1:0]  regi_txdatready  = '0;
    logic [3:0]        regi_packet_type = '0;
    logic [PCNT_W-1:0] regi_tpoll       = '0;
    logic [NLINK-1:0]  dec_flow         = '0;
    logic [NLINK-1:0]  txARQN           = '0;

    int vectors     = 0;
    int miscompares = 0;

    acl_master_txsched_if u_if ();

    acl_master_txsched #(
        .NLINK     (NLINK),
        .PCNT_W    (PCNT_W),
        .POLL_TYPE (4'h1),
        .NULL_TYPE (4'h0)
    ) dut (
        .clk_6M           (clk_6M),
        .rstz             (rstz),
        .sched_en         (sched_en),
        .regi_link_active (regi_link_active),
        .regi_txdatready  (regi_txdatready),
        .regi_packet_type (regi_packet_type),
        .regi_tpoll       (regi_tpoll),
        .dec_flow         (dec_flow),
        .txARQN           (txARQN),
        .slot_if          (u_if)
    );

    always #83 clk_6M = ~clk_6M;

    // {pulse, busy, addr, type}
    function automatic logic [8:0] obs();
        return {u_if.sched_txcmd_p, u_if.sched_busy, u_if.txpk_lt_addr, u_if.txpktype};
    endfunction

    task automatic do_reset();
        @(posedge clk_6M); #1;
        rstz              = 1'b0;
        sched_en          = 1'b0;
        u_if.ms_tslot_p     = 1'b0;
        u_if.ms_TXslot_endp = 1'b0;
        u_if.ms_RXslot_endp = 1'b0;
        u_if.esco_slot      = 1'b0;
        regi_link_active  = '0;
        regi_txdatready   = '0;
        regi_packet_type  = '0;
        regi_tpoll        = '0;
        dec_flow          = '0;
        txARQN            = '0;
        repeat (2) @(posedge clk_6M);
        #1;
        rstz     = 1'b1;
        sched_en = 1'b1;
    endtask

    // Strobe a slot; returns at the sample point of cycle T+2.
    task automatic slot_strobe();
        @(posedge clk_6M); #1;
        u_if.ms_tslot_p = 1'b1;
        @(posedge clk_6M); #1;
        u_if.ms_tslot_p = 1'b0;
        @(posedge clk_6M); #1;
    endtask

    task automatic close_slot();
        u_if.ms_TXslot_endp = 1'b1;
        @(posedge clk_6M); #1;
        u_if.ms_TXslot_endp = 1'b0;
        u_if.ms_RXslot_endp = 1'b1;
        @(posedge clk_6M); #1;
        u_if.ms_RXslot_endp = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        do_reset();
        got = {obs(), u_if.sched_err_p};
        vectors++;
        if (got !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=%b", got, 10'b0);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_addr [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
        logic [8:0] got, exp;
        do_reset();
        regi_link_active = 8'h06;
        regi_txdatready  = 8'h06;
        dec_flow         = 8'hFF;
        regi_packet_type = 4'h4;
        for (int s = 0; s < 4; s++) begin
            slot_strobe();
            got = obs();
            exp = {1'b1, 1'b1, exp_addr[s], 4'h4};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rr_grant slot%0d got=%b exp=%b", s + 1, got, exp);
            end
            @(posedge clk_6M); #1;
            vectors++;
            if ({u_if.sched_txcmd_p, u_if.sched_busy} !== 2'b01) begin
                miscompares++;
                $display("FAIL rr_pulse_width slot%0d got=%b exp=01", s + 1, {u_if.sched_txcmd_p, u_if.sched_busy});
            end
            close_slot();
            vectors++;
            if (u_if.sched_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_busy_release slot%0d got=%b exp=0", s + 1, u_if.sched_busy);
            end
        end
    endtask

    task automatic test_poll_interval();
        logic [8:0] exp_v [6] = '{9'b0_0_000_0000, 9'b0_0_000_0000, 9'b1_1_001_0001,
                                  9'b0_0_001_0001, 9'b0_0_001_0001, 9'b1_1_001_0001};
        logic [8:0] got;
        do_reset();
        regi_link_active = 8'h02;
        regi_tpoll       = 8'd3;
        for (int s = 0; s < 6; s++) begin
            slot_strobe();
            got = obs();
            vectors++;
            if (got !== exp_v[s]) begin
                miscompares++;
                $display("FAIL poll slot%0d got=%b exp=%b", s + 1, got, exp_v[s]);
            end
            if (exp_v[s][8]) close_slot();
        end
    endtask

    task automatic test_class_priority();
        logic [8:0] got;
        do_reset();
        regi_link_active = 8'h0E;
        regi_txdatready  = 8'h04;
        dec_flow         = 8'h00;
        txARQN           = 8'h08;
        for (int s = 0; s < 3; s++) begin
            slot_strobe();
            got = obs();
            vectors++;
            if (got !== 9'b1_1_011_0000) begin
                miscompares++;
                $display("FAIL ack_only slot%0d got=%b exp=%b", s + 1, got, 9'b1_1_011_0000);
            end
            close_slot();
        end
    endtask

    task automatic test_esco_block();
        logic [8:0] got;
        do_reset();
        regi_link_active = 8'h06;
        regi_txdatready  = 8'h02;
        dec_flow         = 8'hFF;
        regi_packet_type = 4'h9;
        regi_tpoll       = 8'd3;
        u_if.esco_slot   = 1'b1;
        slot_strobe();
        u_if.esco_slot   = 1'b0;
        got = obs();
        vectors++;
        if (got !== 9'b0) begin
            miscompares++;
            $display("FAIL esco_no_grant got=%b exp=%b", got, 9'b0);
        end
        slot_strobe();
        got = obs();
        vectors++;
        if (got !== 9'b1_1_001_1001) begin
            miscompares++;
            $display("FAIL esco_next_grant got=%b exp=%b", got, 9'b1_1_001_1001);
        end
        close_slot();
        // Link 2 reaches the poll interval only if the eSCO slot was counted.
        regi_txdatready = 8'h00;
        slot_strobe();
        got = obs();
        vectors++;
        if (got !== 9'b1_1_010_0001) begin
            miscompares++;
            $display("FAIL esco_counter_poll got=%b exp=%b", got, 9'b1_1_010_0001);
        end
        close_slot();
    endtask

    task automatic test_overrun_and_disable();
        logic [8:0] got;
        logic       any_pulse;
        do_reset();
        regi_link_active = 8'h02;
        regi_txdatready  = 8'h02;
        dec_flow         = 8'hFF;
        regi_packet_type = 4'h5;
        slot_strobe();
        got = obs();
        vectors++;
        if (got !== 9'b1_1_001_0101) begin
            miscompares++;
            $display("FAIL ovr_grant got=%b exp=%b", got, 9'b1_1_001_0101);
        end
        u_if.ms_TXslot_endp = 1'b1;
        @(posedge clk_6M); #1;
        u_if.ms_TXslot_endp = 1'b0;
        u_if.ms_tslot_p     = 1'b1;
        @(posedge clk_6M); #1;
        u_if.ms_tslot_p     = 1'b0;
        vectors++;
        if ({u_if.sched_err_p, u_if.sched_txcmd_p} !== 2'b10) begin
            miscompares++;
            $display("FAIL ovr_err_pulse got=%b exp=10", {u_if.sched_err_p, u_if.sched_txcmd_p});
        end
        any_pulse = 1'b0;
        @(posedge clk_6M); #1;
        vectors++;
        if ({u_if.sched_err_p, u_if.sched_busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL ovr_err_width got=%b exp=01", {u_if.sched_err_p, u_if.sched_busy});
        end
        u_if.ms_RXslot_endp = 1'b1;
        @(posedge clk_6M); #1;
        u_if.ms_RXslot_endp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            any_pulse = any_pulse | u_if.sched_txcmd_p | u_if.sched_busy;
            @(posedge clk_6M); #1;
        end
        vectors++;
        if (any_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_no_grant got=%b exp=0", any_pulse);
        end
        slot_strobe();
        got = obs();
        vectors++;
        if (got !== 9'b1_1_001_0101) begin
            miscompares++;
            $display("FAIL dis_grant got=%b exp=%b", got, 9'b1_1_001_0101);
        end
        sched_en = 1'b0;
        @(posedge clk_6M); #1;
        vectors++;
        if ({u_if.sched_txcmd_p, u_if.sched_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL dis_idle got=%b exp=00", {u_if.sched_txcmd_p, u_if.sched_busy});
        end
        sched_en = 1'b1;
        slot_strobe();
        got = obs();
        vectors++;
        if (got !== 9'b1_1_001_0101) begin
            miscompares++;
            $display("FAIL dis_recover got=%b exp=%b", got, 9'b1_1_001_0101);
        end
        close_slot();
    endtask

    task automatic test_async_reset();
        logic [9:0] got;
        logic       any_pulse;
        do_reset();
        regi_link_active = 8'h06;
        regi_txdatready  = 8'h06;
        dec_flow         = 8'hFF;
        regi_packet_type = 4'h7;
        slot_strobe();
        got = {obs(), u_if.sched_err_p};
        vectors++;
        if (got !== 10'b1_1_001_0111_0) begin
            miscompares++;
            $display("FAIL arst_pre_grant got=%b exp=%b", got, 10'b1_1_001_0111_0);
        end
        #20;
        rstz = 1'b0;
        #1;
        got = {obs(), u_if.sched_err_p};
        vectors++;
        if (got !== 10'b0) begin
            miscompares++;
            $display("FAIL arst_immediate got=%b exp=%b", got, 10'b0);
        end
        @(posedge clk_6M); #1;
        rstz = 1'b1;
        any_pulse = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_6M); #1;
            any_pulse = any_pulse | u_if.sched_txcmd_p;
        end
        vectors++;
        if (any_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_release_pulse got=%b exp=0", any_pulse);
        end
        slot_strobe();
        got = {obs(), u_if.sched_err_p};
        vectors++;
        if (got !== 10'b1_1_001_0111_0) begin
            miscompares++;
            $display("FAIL arst_rr_restart got=%b exp=%b", got, 10'b1_1_001_0111_0);
        end
        close_slot();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_poll_interval();
        test_class_priority();
        test_esco_block();
        test_overrun_and_disable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
